// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe register pipeline.
// Optional occupancy counter is enabled with DFF_PIPE_COUNT_EN.
package dff_pkg;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Fill bit for stage data on reset and on flush; replicated to WIDTH.
    localparam logic DATA_RST = 1'b0;

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit.
// Accepts whenever empty or when the downstream stage is draining.
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    // An empty stage always takes, which is what collapses bubbles under stall.
    assign rdy = !vld || dn_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld  <= 1'b0;
            data <= {WIDTH{DATA_RST}};
        end else if (clr) begin
            vld  <= 1'b0;
            data <= {WIDTH{DATA_RST}};
        end else if (rdy) begin
            vld <= up_valid;
            // Data only moves with a real word so out_data stays stable between words.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse and flush.
// Define DFF_PIPE_COUNT_EN to add the registered occupancy output 'count'.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_COUNT_EN
    ,
    output logic [cnt_w(DEPTH)-1:0] count
`endif
);

    logic [DEPTH:0]                rdy;
    logic [DEPTH-1:0]              vld;
    logic [DEPTH-1:0][WIDTH-1:0]   data;

    assign rdy[DEPTH] = out_ready;
    assign in_ready   = rdy[0] && !clr;
    assign out_valid  = vld[DEPTH-1];
    assign out_data   = data[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = vld[i-1];
            assign up_d = data[i-1];
        end

        dff_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (rdy[i+1]),
            .vld      (vld[i]),
            .data     (data[i]),
            .rdy      (rdy[i])
        );
    end

`ifdef DFF_PIPE_COUNT_EN
    localparam int CW = cnt_w(DEPTH);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CW'(1);
        end
    end

    // The counter is a shadow of the valid bits; any drift is a design bug.
    a_count_matches_vld: assert property (@(posedge clk) disable iff (!rst)
        count == CW'($countones(vld)));
    a_count_in_range: assert property (@(posedge clk) disable iff (!rst)
        count <= CW'(DEPTH));
`endif

    a_out_hold: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready && !clr) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: three configurations, a queue/age reference model and
// directed vectors on the WIDTH=8/DEPTH=3 instance. Honours DFF_PIPE_COUNT_EN.
module tb_dff_pipe;
    import dff_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0]  in_valid_a  = '0;
    logic [2:0]  out_ready_a = '0;
    logic [2:0]  clr_a       = '0;
    logic [31:0] in_data_a [3];
    logic [2:0]  in_ready_a;
    logic [2:0]  out_valid_a;
    logic [31:0] out_data_a [3];
`ifdef DFF_PIPE_COUNT_EN
    int cnt_a [3];
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instance 0: W8/D3 (directed), 1: W1/D1, 2: W32/D8.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int W = (k == 0) ? 8 : (k == 1) ? 1 : 32;
        localparam int D = (k == 0) ? 3 : (k == 1) ? 1 : 8;
        localparam logic [31:0] MASK = 32'((64'd1 << W) - 64'd1);

        logic [W-1:0] od;
`ifdef DFF_PIPE_COUNT_EN
        logic [cnt_w(D)-1:0] cnt;
        assign cnt_a[k] = int'(cnt);
`endif

        dff_pipe #(.WIDTH(W), .DEPTH(D)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr_a[k]),
            .in_valid  (in_valid_a[k]),
            .in_ready  (in_ready_a[k]),
            .in_data   (in_data_a[k][W-1:0]),
            .out_valid (out_valid_a[k]),
            .out_ready (out_ready_a[k]),
            .out_data  (od)
`ifdef DFF_PIPE_COUNT_EN
            ,
            .count     (cnt)
`endif
        );
        assign out_data_a[k] = 32'(od);

        // Model: FIFO of accepted words with the edge each was accepted on.
        // The oldest word never waits behind anything, so it is presented
        // exactly D-1 edges after acceptance; in_ready is "any room or draining".
        logic [31:0] q_d [$];
        int          q_e [$];
        int          edge_n = 0;
        logic [31:0] last_out = '0;
        logic        exp_ov, exp_ir, in_x, out_x;
        logic [31:0] exp_od, dv;

        initial forever begin
            @(negedge clk);
            if (!rst) begin
                q_d.delete(); q_e.delete(); last_out = '0;
            end
            exp_ov = (q_d.size() > 0) && (edge_n - q_e[0] >= D - 1);
            exp_od = exp_ov ? q_d[0] : last_out;
            exp_ir = !clr_a[k] && (out_ready_a[k] || q_d.size() < D);
            chk($sformatf("m%0d out_valid", k), 32'(out_valid_a[k]), 32'(exp_ov));
            chk($sformatf("m%0d out_data", k), out_data_a[k], exp_od);
            chk($sformatf("m%0d in_ready", k), 32'(in_ready_a[k]), 32'(exp_ir));
`ifdef DFF_PIPE_COUNT_EN
            chk($sformatf("m%0d count", k), 32'(cnt_a[k]), 32'(q_d.size()));
`endif
            in_x  = in_valid_a[k] && exp_ir;
            out_x = exp_ov && out_ready_a[k];
            dv    = in_data_a[k] & MASK;
            @(posedge clk);
            edge_n++;
            if (!rst || clr_a[k]) begin
                q_d.delete(); q_e.delete(); last_out = '0;
            end else begin
                if (exp_ov) last_out = q_d[0];
                if (out_x) begin void'(q_d.pop_front()); void'(q_e.pop_front()); end
                if (in_x) begin q_d.push_back(dv); q_e.push_back(edge_n); end
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic neg();  @(negedge clk); #1; endtask

    task automatic drive(input int k, input logic v, input logic [31:0] d);
        in_valid_a[k] = v;
        in_data_a[k]  = d;
    endtask

    task automatic sweep(input int k, input int depth);
        out_ready_a[k] = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); drive(k, 1'b1, 32'h100 + 32'(i)); end
        tick(); drive(k, 1'b0, '0);
        repeat (depth + 2) tick();
        out_ready_a[k] = 1'b0;
        for (int i = 0; i < depth + 3; i++) begin tick(); drive(k, 1'b1, 32'hBEEF0000 + 32'(i)); end
        tick(); drive(k, 1'b0, '0); out_ready_a[k] = 1'b1;
        repeat (depth + 2) tick();
        for (int i = 0; i < 300; i++) begin
            tick();
            drive(k, 1'($urandom_range(0, 1)), $urandom);
            out_ready_a[k] = 1'($urandom_range(0, 3) != 0);
            clr_a[k]       = ($urandom_range(0, 39) == 0);
        end
        tick(); drive(k, 1'b0, '0); clr_a[k] = 1'b0; out_ready_a[k] = 1'b1;
        repeat (depth + 2) tick();
    endtask

    initial begin
        foreach (in_data_a[i]) in_data_a[i] = '0;
        #1 rst = 1'b0;
        neg();
        chk("reset out_valid", 32'(out_valid_a[0]), 32'd0);
        chk("reset out_data", out_data_a[0], 32'h00);
        rst = 1'b1; #1;
        chk("release in_ready", 32'(in_ready_a[0]), 32'd1);

        // Streaming 0x01..0x10, first word visible two edges after acceptance.
        out_ready_a[0] = 1'b1;
        tick(); drive(0, 1'b1, 32'h01);
        for (int j = 1; j <= 18; j++) begin
            tick();
            if (j < 16) drive(0, 1'b1, 32'(j + 1)); else drive(0, 1'b0, '0);
            neg();
            chk("stream out_valid", 32'(out_valid_a[0]), 32'(j >= 3));
            if (j >= 3) chk("stream out_data", out_data_a[0], 32'(j - 2));
        end

        // Backpressure: three fit, the fourth waits until out_ready returns.
        tick(); out_ready_a[0] = 1'b0; drive(0, 1'b1, 32'h11);
        tick(); drive(0, 1'b1, 32'h22);
        tick(); drive(0, 1'b1, 32'h33);
        tick(); drive(0, 1'b1, 32'h44);
        neg();
        chk("bp full in_ready", 32'(in_ready_a[0]), 32'd0);
        chk("bp head data", out_data_a[0], 32'h11);
`ifdef DFF_PIPE_COUNT_EN
        chk("bp count", 32'(cnt_a[0]), 32'd3);
`endif
        tick(); neg();
        chk("bp still blocked", 32'(in_ready_a[0]), 32'd0);
        tick(); out_ready_a[0] = 1'b1;
        neg();
        chk("bp ready passthru", 32'(in_ready_a[0]), 32'd1);
        tick(); drive(0, 1'b0, '0); neg();
        chk("bp order 22", out_data_a[0], 32'h22);
        tick(); neg();
        chk("bp order 33", out_data_a[0], 32'h33);
        tick(); neg();
        chk("bp order 44", out_data_a[0], 32'h44);

        // Bubble collapse: 0x55, two gaps, 0x66 under stall.
        tick(); out_ready_a[0] = 1'b0; drive(0, 1'b1, 32'h55);
        tick(); drive(0, 1'b0, '0);
        tick(); tick(); drive(0, 1'b1, 32'h66);
        tick(); drive(0, 1'b0, '0);
        tick(); neg();
        chk("bubble head", out_data_a[0], 32'h55);
        chk("bubble in_ready", 32'(in_ready_a[0]), 32'd1);
`ifdef DFF_PIPE_COUNT_EN
        chk("bubble count", 32'(cnt_a[0]), 32'd2);
`endif
        tick(); out_ready_a[0] = 1'b1;
        tick(); neg();
        chk("bubble 66 in stage1", out_data_a[0], 32'h66);

        // Flush with a full pipe; 0x77 offered during clr must vanish.
        tick(); out_ready_a[0] = 1'b0; drive(0, 1'b1, 32'h81);
        tick(); drive(0, 1'b1, 32'h82);
        tick(); drive(0, 1'b1, 32'h83);
        tick(); drive(0, 1'b1, 32'h77); clr_a[0] = 1'b1;
        neg();
        chk("clr in_ready", 32'(in_ready_a[0]), 32'd0);
        chk("clr pre-clear data", out_data_a[0], 32'h81);
        tick(); clr_a[0] = 1'b0; drive(0, 1'b0, '0); out_ready_a[0] = 1'b1;
        neg();
        chk("clr out_valid", 32'(out_valid_a[0]), 32'd0);
        chk("clr out_data", out_data_a[0], 32'h00);
`ifdef DFF_PIPE_COUNT_EN
        chk("clr count", 32'(cnt_a[0]), 32'd0);
`endif
        repeat (4) begin
            tick(); neg();
            chk("clr no 77", 32'(out_valid_a[0]), 32'd0);
        end

        // Asynchronous reset mid-clock with words in flight and 0xA5 offered.
        tick(); drive(0, 1'b1, 32'h90);
        tick(); drive(0, 1'b1, 32'h91);
        tick(); drive(0, 1'b1, 32'hA5);
        #1 rst = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid_a[0]), 32'd0);
        chk("async rst out_data", out_data_a[0], 32'h00);
`ifdef DFF_PIPE_COUNT_EN
        chk("async rst count", 32'(cnt_a[0]), 32'd0);
`endif
        neg(); rst = 1'b1; #1;
        chk("rst release in_ready", 32'(in_ready_a[0]), 32'd1);
        tick(); drive(0, 1'b0, '0);
        repeat (5) tick();

        for (int k = 0; k < 3; k++) begin
            sweep(k, (k == 0) ? 3 : (k == 1) ? 1 : 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
